rf_write_sched: RTL and testbench

RF_WRITE_SCHED -- requirements
Module: rf_write_sched

---
 rtl/rf_pkg.sv | 9 +
 rtl/rr_arb2.sv | 29 ++
 rtl/rf_write_sched.sv | 125 ++++++++++++
 tb/tb_rf_write_sched.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and enums for the register-file write scheduler.
package rf_pkg;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned NREGS  = 8;
    localparam int unsigned ADDR_W = 3;

    typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;
    typedef enum logic {REQ_ALU = 1'b0, REQ_LD = 1'b1} req_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: req[0]=ALU, req[1]=load; one-hot grant.
module rr_arb2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] grant
);
    req_t prefer;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (prefer == REQ_ALU) ? 2'b01 : 2'b10;
        end
    end

    // Any grant is an accept here, so the loser of the last grant is preferred next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prefer <= REQ_ALU;
        end else if (grant[0]) begin
            prefer <= REQ_LD;
        end else if (grant[1]) begin
            prefer <= REQ_ALU;
        end
    end
endmodule

// File: rtl/rf_write_sched.sv
// Clears the register file after reset, then schedules ALU and load writebacks
// onto its single write port with a one-cycle registered latency.
module rf_write_sched #(
    parameter int unsigned DATA_W = rf_pkg::DATA_W,
    parameter int unsigned NREGS  = rf_pkg::NREGS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alu_valid,
    input  logic [rf_pkg::ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0]         alu_data,
    input  logic                      alu_cout_we,
    input  logic [DATA_W-1:0]         alu_cout,
    output logic                      alu_ready,
    input  logic                      ld_valid,
    input  logic [rf_pkg::ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0]         ld_data,
    output logic                      ld_ready,
    output logic [rf_pkg::ADDR_W-1:0] rt_o,
    output logic                      write_enable_o,
    output logic [DATA_W-1:0]         write_data_o,
    output logic                      cout_write_enable_o,
    output logic [DATA_W-1:0]         cout_data_o,
    output logic [NREGS-1:0]          pending_o,
    output logic                      init_done_o
);
    import rf_pkg::*;

    localparam int unsigned CNT_W = $clog2(NREGS + 1);

    state_t               state, state_next;
    logic [CNT_W-1:0]     init_cnt, init_cnt_next;
    logic                 init_done_next;
    logic [1:0]           req, grant;
    logic [ADDR_W-1:0]    rt_next;
    logic                 we_next, cwe_next;
    logic [DATA_W-1:0]    wd_next, cd_next;
    logic [NREGS-1:0]     pend_next;
    logic                 accept;
    logic [ADDR_W-1:0]    acc_addr;

    assign req       = (state == S_RUN) ? {ld_valid, alu_valid} : 2'b00;
    assign alu_ready = grant[0];
    assign ld_ready  = grant[1];

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .grant (grant)
    );

    always_comb begin
        state_next     = state;
        init_cnt_next  = init_cnt;
        init_done_next = init_done_o;
        rt_next        = rt_o;
        wd_next        = write_data_o;
        cd_next        = cout_data_o;
        we_next        = 1'b0;
        cwe_next       = 1'b0;
        accept         = 1'b0;
        acc_addr       = '0;
        pend_next      = '0;
        unique case (state)
            S_INIT: begin
                if (init_cnt == CNT_W'(NREGS)) begin
                    state_next     = S_RUN;
                    init_done_next = 1'b1;
                end else begin
                    we_next       = 1'b1;
                    rt_next       = ADDR_W'(init_cnt);
                    wd_next       = '0;
                    init_cnt_next = init_cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (grant[0]) begin
                    accept   = 1'b1;
                    acc_addr = alu_addr;
                    we_next  = 1'b1;
                    rt_next  = alu_addr;
                    wd_next  = alu_data;
                    cwe_next = alu_cout_we;
                    cd_next  = alu_cout;
                end else if (grant[1]) begin
                    accept   = 1'b1;
                    acc_addr = ld_addr;
                    we_next  = 1'b1;
                    rt_next  = ld_addr;
                    wd_next  = ld_data;
                end
            end
            default: state_next = S_INIT;
        endcase
        // A fresh accept re-sets its bit; everything else clears after one cycle.
        for (int unsigned i = 0; i < NREGS; i++) begin
            pend_next[i] = accept && (acc_addr == ADDR_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= S_INIT;
            init_cnt            <= '0;
            init_done_o         <= 1'b0;
            rt_o                <= '0;
            write_enable_o      <= 1'b0;
            write_data_o        <= '0;
            cout_write_enable_o <= 1'b0;
            cout_data_o         <= '0;
            pending_o           <= '0;
        end else begin
            state               <= state_next;
            init_cnt            <= init_cnt_next;
            init_done_o         <= init_done_next;
            rt_o                <= rt_next;
            write_enable_o      <= we_next;
            write_data_o        <= wd_next;
            cout_write_enable_o <= cwe_next;
            cout_data_o         <= cd_next;
            pending_o           <= pend_next;
        end
    end
endmodule

// File: tb/tb_rf_write_sched.sv
// Directed plus randomized bench for rf_write_sched against a transaction-level model.
module tb_rf_write_sched;
    localparam int DW = 8;
    localparam int NR = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0, alu_cout_we = 1'b0, ld_valid = 1'b0;
    logic [2:0]    alu_addr = '0, ld_addr = '0;
    logic [DW-1:0] alu_data = '0, alu_cout = '0, ld_data = '0;
    logic          alu_ready, ld_ready;
    logic [2:0]    rt_o;
    logic          write_enable_o, cout_write_enable_o, init_done_o;
    logic [DW-1:0] write_data_o, cout_data_o;
    logic [NR-1:0] pending_o;

    int total = 0;
    int bad   = 0;

    rf_write_sched #(.DATA_W(DW), .NREGS(NR)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .alu_valid           (alu_valid),
        .alu_addr            (alu_addr),
        .alu_data            (alu_data),
        .alu_cout_we         (alu_cout_we),
        .alu_cout            (alu_cout),
        .alu_ready           (alu_ready),
        .ld_valid            (ld_valid),
        .ld_addr             (ld_addr),
        .ld_data             (ld_data),
        .ld_ready            (ld_ready),
        .rt_o                (rt_o),
        .write_enable_o      (write_enable_o),
        .write_data_o        (write_data_o),
        .cout_write_enable_o (cout_write_enable_o),
        .cout_data_o         (cout_data_o),
        .pending_o           (pending_o),
        .init_done_o         (init_done_o)
    );

    always #5 clk = ~clk;

    // Register file as seen through the DUT's write port.
    logic [DW-1:0] rf_shadow [NR];
    always @(posedge clk) if (write_enable_o) rf_shadow[rt_o] <= write_data_o;

    // Reference model: init progress, last winner, and next expected outputs.
    bit            m_run;
    int            m_init;
    int            m_last;   // 0 = ALU won last, 1 = load won last
    bit            e_ar, e_lr, e_we, e_cwe, e_done;
    logic [2:0]    e_rt;
    logic [DW-1:0] e_wd, e_cd;
    logic [NR-1:0] e_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_init = 0; m_last = 1;
        e_we = 0; e_cwe = 0; e_done = 0;
        e_rt = '0; e_wd = '0; e_cd = '0; e_pend = '0;
    endtask

    task automatic check_outputs();
        chk("rt_o", rt_o, e_rt);
        chk("write_enable_o", write_enable_o, e_we);
        chk("write_data_o", write_data_o, e_wd);
        chk("cout_write_enable_o", cout_write_enable_o, e_cwe);
        chk("cout_data_o", cout_data_o, e_cd);
        chk("pending_o", pending_o, e_pend);
        chk("init_done_o", init_done_o, e_done);
    endtask

    // One clock: inputs are already applied; check readys, predict, clock, check.
    task automatic cycle();
        e_ar = 0; e_lr = 0;
        if (m_run) begin
            if (alu_valid && ld_valid) begin
                e_ar = (m_last == 1);
                e_lr = (m_last == 0);
            end else begin
                e_ar = alu_valid;
                e_lr = ld_valid;
            end
        end
        #1;
        chk("alu_ready", alu_ready, e_ar);
        chk("ld_ready", ld_ready, e_lr);
        e_we = 0; e_cwe = 0; e_pend = '0;
        if (!m_run) begin
            if (m_init < NR) begin
                e_we = 1; e_rt = 3'(m_init); e_wd = '0;
                m_init++;
            end else begin
                m_run = 1; e_done = 1;
            end
        end else if (e_ar) begin
            e_we = 1; e_rt = alu_addr; e_wd = alu_data;
            e_cwe = alu_cout_we; e_cd = alu_cout;
            e_pend[alu_addr] = 1'b1;
            m_last = 0;
        end else if (e_lr) begin
            e_we = 1; e_rt = ld_addr; e_wd = ld_data;
            e_pend[ld_addr] = 1'b1;
            m_last = 1;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        alu_valid = 0; ld_valid = 0; alu_cout_we = 0;
    endtask

    task automatic rand_inputs();
        alu_valid   = 1'($urandom_range(0, 1));
        ld_valid    = 1'($urandom_range(0, 1));
        alu_addr    = 3'($urandom_range(0, 7));
        ld_addr     = 3'($urandom_range(0, 7));
        alu_data    = 8'($urandom);
        ld_data     = 8'($urandom);
        alu_cout_we = 1'($urandom_range(0, 1));
        alu_cout    = 8'($urandom);
    endtask

    initial begin
        // Reset state
        model_reset();
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("reset_alu_ready", alu_ready, 1'b0);
        chk("reset_ld_ready", ld_ready, 1'b0);

        // Clear sequence: 8 writes of 0, then init_done
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < NR + 1; i++) cycle();
        chk("init_done_after_clear", init_done_o, 1'b1);
        cycle();

        // Single ALU write with carry
        alu_valid = 1; alu_addr = 3; alu_data = 8'h5A; alu_cout_we = 1; alu_cout = 8'h01;
        cycle();
        idle_inputs();
        chk("alu_write_pending3", pending_o[3], 1'b1);
        cycle();
        chk("alu_write_pending3_clear", pending_o[3], 1'b0);
        cycle();

        // Single load after an ALU win
        ld_valid = 1; ld_addr = 6; ld_data = 8'h66;
        cycle();
        idle_inputs();
        cycle();

        // Continuous contention: alternates ALU, LD, ALU ...
        alu_valid = 1; alu_addr = 1; alu_data = 8'h11; alu_cout_we = 1; alu_cout = 8'hC1;
        ld_valid = 1; ld_addr = 2; ld_data = 8'h22;
        for (int i = 0; i < 6; i++) cycle();
        idle_inputs();
        cycle();

        // Same address from both sides: serialized, later grant wins
        alu_valid = 1; alu_addr = 5; alu_data = 8'hAA; alu_cout_we = 0;
        ld_valid = 1; ld_addr = 5; ld_data = 8'hBB;
        cycle();
        chk("same_addr_first", write_data_o, 8'hAA);
        alu_valid = 0;
        cycle();
        chk("same_addr_second", write_data_o, 8'hBB);
        chk("same_addr_pending5_held", pending_o[5], 1'b1);
        idle_inputs();
        cycle();
        chk("r5_final", rf_shadow[5], 8'hBB);

        // Load-only stream of 10 back-to-back requests
        for (int i = 0; i < 10; i++) begin
            ld_valid = 1; ld_addr = 3'($urandom_range(0, 7)); ld_data = 8'($urandom);
            cycle();
        end
        idle_inputs();
        cycle();

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            rand_inputs();
            cycle();
        end
        idle_inputs();
        cycle();

        // Reset during init write 4, then the clear sequence restarts from 0
        @(negedge clk);
        rst_n = 0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 5; i++) cycle();
        chk("init_write4_seen", rt_o, 3'd4);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_outputs();
        chk("abort_ready", ld_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        cycle();
        chk("restart_addr0", rt_o, 3'd0);
        for (int i = 0; i < NR; i++) cycle();
        for (int i = 0; i < 40; i++) begin
            rand_inputs();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
